// File: rtl/uart_tx.sv
// 8N1/8N2 serial transmitter with one-cycle active-low acknowledge toward the register block.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry byte queue ahead of the frame FSM.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       get_n,
   output logic       tx,
   output logic       busy,
   output logic       full
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2) begin : g_bad_param
      $error("uart_tx: illegal parameter value");
   end

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic            stop_q, stop_d;
   logic [7:0]      shift_q, shift_d;
   logic            get_n_q;

   logic       accept;
   logic       avail;
   logic       pop;
   logic [7:0] head;

   // get_n low blocks sampling, so a level-held in_valid yields one byte per write.
   assign accept = in_valid && !full && get_n_q;
   assign get_n  = get_n_q;

`ifdef UART_TX_FIFO_EN
   localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

   logic [7:0]     mem_q [FIFO_DEPTH];
   logic [AddrW:0] wr_q, rd_q;

   assign avail = (wr_q != rd_q);
   assign full  = (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]) && (wr_q[AddrW] != rd_q[AddrW]);
   assign head  = mem_q[rd_q[AddrW-1:0]];
   assign busy  = (state_q != StIdle) || avail;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (accept) wr_q <= wr_q + 1'b1;
         if (pop)    rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_q[AddrW-1:0]] <= in_data;
   end
`else
   logic [7:0] hold_q;
   logic       hold_valid_q;

   assign avail = hold_valid_q;
   assign full  = (state_q != StIdle);
   assign head  = hold_q;
   assign busy  = (state_q != StIdle) || hold_valid_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else if (accept) begin
         hold_q       <= in_data;
         hold_valid_q <= 1'b1;
      end else if (pop) begin
         hold_valid_q <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         get_n_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         get_n_q <= !accept;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      pop     = 1'b0;
      if (state_q != StIdle) cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (avail) begin
               pop     = 1'b1;
               shift_d = head;
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q == CntMax) begin
               bit_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (cnt_q == CntMax) begin
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
                  stop_d  = 1'b0;
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (cnt_q == CntMax) begin
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  // Chain straight into the next START so queued bytes leave no idle gap.
                  if (avail) begin
                     pop     = 1'b1;
                     shift_d = head;
                     state_d = StStart;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      unique case (state_q)
         StStart: tx = 1'b0;
         StData:  tx = shift_q[0];
         default: tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance with one stop bit, one with two, CLKS_PER_BIT = 4.
// Build with +define+UART_TX_FIFO_EN to exercise the queued path instead of the single-byte path.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int unsigned Cpb = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data1 = '0, in_data2 = '0;
   logic       in_valid1 = 1'b0, in_valid2 = 1'b0;
   logic       get_n1, tx1, busy1, full1;
   logic       get_n2, tx2, busy2, full2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(Cpb), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
      .get_n(get_n1), .tx(tx1), .busy(busy1), .full(full1)
   );

   uart_tx #(.CLKS_PER_BIT(Cpb), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
      .get_n(get_n2), .tx(tx2), .busy(busy2), .full(full2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic tx_of(input int sel);
      return (sel == 0) ? tx1 : tx2;
   endfunction

   // Upstream handshake: raise valid, wait for the acknowledge, drop valid.
   task automatic send(input int sel, input logic [7:0] b, output int waited);
      waited = 0;
      if (sel == 0) begin in_data1 = b; in_valid1 = 1'b1; end
      else begin in_data2 = b; in_valid2 = 1'b1; end
      for (int i = 0; i < 200; i++) begin
         tick();
         if (((sel == 0) ? get_n1 : get_n2) == 1'b0) break;
         waited++;
      end
      if (sel == 0) in_valid1 = 1'b0;
      else in_valid2 = 1'b0;
      if (waited >= 200) begin
         n_checks++;
         $display("FAIL send_timeout: no acknowledge for byte 0x%0h within 200 cycles", b);
      end
   endtask

   // Records tx once per cycle over a whole frame and compares it against the ideal waveform.
   task automatic capture(input int sel, input logic [7:0] b, input int stop_bits,
                          input bit started, output int gap);
      logic [63:0] got, exp;
      int len, bitno;
      got = '0;
      exp = '0;
      gap = 0;
      len = (9 + stop_bits) * Cpb;
      if (!started) begin
         for (int i = 0; i < 400; i++) begin
            tick();
            if (tx_of(sel) == 1'b0) break;
            gap++;
         end
         if (gap >= 400) begin
            n_checks++;
            $display("FAIL start_timeout: no start bit for byte 0x%0h", b);
         end
      end
      for (int c = 0; c < len; c++) begin
         if (c > 0) tick();
         got[c] = tx_of(sel);
         bitno  = c / Cpb;
         exp[c] = (bitno == 0) ? 1'b0 : (bitno <= 8) ? b[bitno-1] : 1'b1;
      end
      check($sformatf("frame_%02h", b), got, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, g, wp, gc, zeros;

      repeat (3) tick();
      check("reset_tx", tx1, 1'b1);
      check("reset_get_n", get_n1, 1'b1);
      check("reset_busy", busy1, 1'b0);
      check("reset_full", full1, 1'b0);
      check("reset_tx2", tx2, 1'b1);
      rst_n = 1'b1;
      tick();

      // 0x55, one stop bit
      send(0, 8'h55, w);
      check("accept_wait", w, 0);
      tick();
      check("ack_one_cycle", get_n1, 1'b1);
      check("start_latency", tx1, 1'b0);
      capture(0, 8'h55, 1, 1'b1, g);
      check("busy_last_cycle", busy1, 1'b1);
      tick();
      check("busy_after_frame", busy1, 1'b0);
      check("tx_idle_after_frame", tx1, 1'b1);

      // 0xA3, two stop bits: 44-cycle frame
      send(1, 8'hA3, w);
      tick();
      check("start_latency2", tx2, 1'b0);
      capture(1, 8'hA3, 2, 1'b1, g);
      tick();
      check("busy_after_frame2", busy2, 1'b0);

`ifdef UART_TX_FIFO_EN
      fork
         begin
            for (int k = 1; k <= 5; k++) send(0, 8'(k), wp);
            check("full_after_queue", full1, 1'b1);
            send(0, 8'h06, wp);
            check("held_until_pop", wp, 33);
         end
         begin
            capture(0, 8'h01, 1, 1'b0, gc);
            check("first_start_gap", gc, 1);
            for (int k = 2; k <= 6; k++) begin
               capture(0, 8'(k), 1, 1'b0, gc);
               check($sformatf("b2b_gap_%0d", k), gc, 0);
            end
         end
      join
      tick();
      check("busy_after_queue", busy1, 1'b0);
`else
      send(0, 8'h3C, w);
      send(0, 8'hC5, w);
      check("hold_until_idle", w, 41);
      capture(0, 8'hC5, 1, 1'b0, g);
      check("held_byte_gap", g, 0);
      tick();
      check("busy_after_held", busy1, 1'b0);
`endif

      // Reset in the middle of the data bits
      send(0, 8'h0F, w);
`ifdef UART_TX_FIFO_EN
      send(0, 8'hF0, w);
      send(0, 8'hAA, w);
`endif
      repeat (12) tick();
      rst_n = 1'b0;
      tick();
      check("midreset_tx", tx1, 1'b1);
      check("midreset_busy", busy1, 1'b0);
      check("midreset_full", full1, 1'b0);
      check("midreset_get_n", get_n1, 1'b1);
      rst_n = 1'b1;
      zeros = 0;
      repeat (120) begin
         tick();
         if (tx1 == 1'b0) zeros++;
      end
      check("no_tx_after_reset", zeros, 0);
      check("idle_after_reset", busy1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
